seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display.
- Holds one 5-bit entry per digit: hex value plus decimal point.
- Steps a 3-bit digit index, which drives the 3-to-8 digit-select decoder, and produces the matching active-low segment pattern.
- Inserts a blanking guard interval between digits to suppress ghosting.
- Sits between the game logic (register writes) and the board display pins.

Parameters:
DIV_CNT, 100000, clock cycles each digit is lit (SHOW phase); legal range >= 1.
BLANK_CYC, 1000, guard cycles with all segments off before each digit (BLANK phase); legal range >= 0.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
wr_en  in  1  write strobe for the digit register file.
wr_addr  in  3  digit written; 0 = rightmost/least significant, 7 = leftmost.
wr_data  in  5  bit4 = decimal point on, bits3:0 = hex value.
dig_en_mask  in  8  per-digit enable; 0 forces that digit blank.
lz_blank  in  1  leading-zero suppression enable.
dig_sel  out  3  current digit index, fed to the digit-select decoder.
seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}; 8'hFF = all off.
frame_tick  out  1  one-cycle pulse at the end of each full 8-digit frame.

Behaviour:
- Reset (rst low, async, also mid-operation): all 8 registers go to 5'h00. state = BLANK, cnt = 0, dig_sel = 0, seg_n = 8'hFF, frame_tick = 0. All outputs are registered.
- Writes: reg[wr_addr] <= wr_data on the clk edge where wr_en = 1. Writes are accepted in any state.
- State machine, states BLANK and SHOW, with cycle counter cnt:
  - BLANK: seg_n = FF. When cnt == BLANK_CYC-1: state <= SHOW, cnt <= 0, seg_n <= pat(dig_sel).
  - SHOW: each cycle seg_n <= pat(dig_sel), using register contents before that edge's write. A write is therefore visible on seg_n one edge later.
  - SHOW, when cnt == DIV_CNT-1: dig_sel <= dig_sel+1 (7 wraps to 0), cnt <= 0. If BLANK_CYC > 0: state <= BLANK, seg_n <= FF. If BLANK_CYC == 0: stay in SHOW, seg_n <= pat(next dig_sel).
  - dig_sel never changes while a digit is lit.
- frame_tick = 1 for exactly the cycle after the SHOW->next transition of digit 7; 0 otherwise. Frame period = 8*(DIV_CNT+BLANK_CYC) cycles.
- pat(k) = FF if dig_en_mask[k] = 0 or digit k is leading-zero blanked. Otherwise hex7(reg[k][3:0]), with bit7 cleared when reg[k][4] = 1.
- Leading-zero blanking: digit k (k >= 1) is blanked when lz_blank = 1 and every reg[j], j = k..7, equals 5'h00 (value 0, dp off). Digit 0 is never lz-blanked. Masked digits still count by register content.
- dig_en_mask and lz_blank are sampled every cycle; they have no effect on timing.
- hex7 (active-low) for 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- cnt width = clog2(max(DIV_CNT, BLANK_CYC, 2)); no wrap beyond terminal count.

Decomposition:
- Shared package: SEG_OFF = 8'hFF, the hex7 constant table, NUM_DIG = 8.
- One sub-module, seg_hex_encoder: combinational 4-bit hex plus dp -> active-low 8-bit pattern.
- Scan FSM and register file stay in seg_scan_ctrl.

Test Plan:
(All tests use DIV_CNT=4, BLANK_CYC=2 unless stated.)
1. Reset, then release with mask = FF, lz_blank = 0 -> seg_n = FF for 2 cycles, then C0 for 4 cycles with dig_sel = 0. dig_sel becomes 1 together with seg_n returning to FF.
2. Write addr 3 = 5'h05, later addr 3 = 5'h15 -> while dig_sel = 3 in SHOW, seg_n = 92, then 12. Each change appears one edge after the write edge.
3. Free run for 200 cycles -> frame_tick pulses every 48 cycles, each one cycle wide, immediately after digit 7's SHOW ends. dig_sel sequence is 0..7,0.
4. lz_blank = 1, regs digit2 = 1, digit1 = 2, others 0 -> digits 7..3 FF, digit2 F9, digit1 A4, digit0 C0. All regs zero -> only digit0 shows C0.
5. dig_en_mask = 8'b1111_0111 -> digit 3 shows FF for its full slot. Frame period stays 48 cycles.
6. Assert rst mid-SHOW of digit 5 (async, between edges) -> seg_n = FF and dig_sel = 0 immediately. After release, all digits show C0, confirming the registers were cleared.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// the blank pattern, the active-low hex glyph table and the scan states.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIG = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Index 0 is the rightmost entry, so HEX7_TABLE[v] is the glyph for v.
    localparam logic [15:0][7:0] HEX7_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_hex_encoder.sv
// Combinational hex digit plus decimal point to active-low {dp,g..a} pattern.
module seg_hex_encoder
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg_n
);

    assign seg_n = {HEX7_TABLE[hex][7] & ~dp, HEX7_TABLE[hex][6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with per-digit register file,
// blanking guard between digits, masking and leading-zero suppression.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIV_CNT   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] dig_en_mask,
    input  logic       lz_blank,
    output logic [2:0] dig_sel,
    output logic [7:0] seg_n,
    output logic       frame_tick
);

    localparam int CNT_BIG = (DIV_CNT > BLANK_CYC) ? DIV_CNT : BLANK_CYC;
    localparam int CNT_MAX = (CNT_BIG > 2) ? CNT_BIG : 2;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV_CNT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    logic [4:0]   digit_reg [NUM_DIG];
    scan_state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]   sel_nxt;
    logic [7:0]   seg_nxt;
    logic         tick_nxt;

    logic         show_done;
    logic         blank_done;
    logic [2:0]   next_sel;
    logic [2:0]   pat_idx;
    logic [7:0]   lz_hide;
    logic         all_zero;
    logic [7:0]   enc_seg;
    logic [7:0]   pat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                digit_reg[i] <= 5'h00;
            end
        end else if (wr_en) begin
            digit_reg[wr_addr] <= wr_data;
        end
    end

    // A digit is suppressed only if it and everything to its left is exactly zero.
    always_comb begin
        all_zero = 1'b1;
        lz_hide  = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            all_zero   = all_zero & (digit_reg[k] == 5'h00);
            lz_hide[k] = lz_blank & all_zero & (k != 0);
        end
    end

    assign show_done  = (state == ST_SHOW) && (cnt == SHOW_LAST);
    assign blank_done = (state == ST_BLANK) && ((BLANK_CYC == 0) || (cnt == BLANK_LAST));
    assign next_sel   = dig_sel + 3'd1;

    // Without a guard interval the next digit's pattern must be ready at the switch edge.
    assign pat_idx = (show_done && (BLANK_CYC == 0)) ? next_sel : dig_sel;

    seg_hex_encoder u_encoder (
        .hex   (digit_reg[pat_idx][3:0]),
        .dp    (digit_reg[pat_idx][4]),
        .seg_n (enc_seg)
    );

    assign pat = (!dig_en_mask[pat_idx] || lz_hide[pat_idx]) ? SEG_OFF : enc_seg;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        sel_nxt   = dig_sel;
        seg_nxt   = seg_n;
        tick_nxt  = 1'b0;
        case (state)
            ST_BLANK: begin
                seg_nxt = SEG_OFF;
                if (blank_done) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    seg_nxt   = pat;
                end
            end
            ST_SHOW: begin
                seg_nxt = pat;
                if (show_done) begin
                    sel_nxt  = next_sel;
                    cnt_nxt  = '0;
                    tick_nxt = (dig_sel == 3'd7);
                    if (BLANK_CYC > 0) begin
                        state_nxt = ST_BLANK;
                        seg_nxt   = SEG_OFF;
                    end
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
                seg_nxt   = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            dig_sel    <= 3'd0;
            seg_n      <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dig_sel    <= sel_nxt;
            seg_n      <= seg_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV_CNT=4, BLANK_CYC=2 (6-cycle slot,
// 48-cycle frame); per-frame expectations come from a vector table.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLK   = 2;
    localparam int SLOT  = DIV + BLK;
    localparam int FRAME = 8 * SLOT;

    typedef struct {
        logic [7:0][4:0] regs;
        logic [7:0]      mask;
        logic            lz;
        logic [7:0][7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [4:0] wr_data = 5'h00;
    logic [7:0] dig_en_mask = 8'hFF;
    logic       lz_blank = 1'b0;
    logic [2:0] dig_sel;
    logic [7:0] seg_n;
    logic       frame_tick;

    int passCount = 0;
    int checkCount = 0;
    int tNow = 0;
    vec_t vecs [6];

    seg_scan_ctrl #(.DIV_CNT(DIV), .BLANK_CYC(BLK)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .dig_en_mask (dig_en_mask),
        .lz_blank    (lz_blank),
        .dig_sel     (dig_sel),
        .seg_n       (seg_n),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        tNow++;
    endtask

    task automatic stepTo(input int t);
        while (tNow < t) tick();
    endtask

    // Leaves us at the negedge where frame_tick is high: digit 0, first blank cycle (t=0).
    task automatic syncFrame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 4 * FRAME);
        checkOutput("frame_sync", {7'b0, frame_tick}, 8'h01);
        tNow = 0;
    endtask

    task automatic writeRegs(input logic [7:0][4:0] r);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 3'(k);
            wr_data = r[k];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic applyStimulus(input int v);
        writeRegs(vecs[v].regs);
        dig_en_mask = vecs[v].mask;
        lz_blank    = vecs[v].lz;
        syncFrame();
        for (int k = 0; k < 8; k++) begin
            stepTo(SLOT * k + 3);
            checkOutput($sformatf("vec%0d_seg%0d", v, k), seg_n, vecs[v].exp[k]);
            checkOutput($sformatf("vec%0d_sel%0d", v, k), {5'b0, dig_sel}, 8'(k));
        end
    endtask

    task automatic measurePeriod(input string name);
        int n = 0;
        syncFrame();
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 4 * FRAME);
        checkInt(name, n, FRAME);
    endtask

    initial begin
        logic [7:0] startSeg [7];
        logic [2:0] startSel [7];
        int lastTick;
        int ticks;
        logic prevTick;
        logic [2:0] prevSel;

        vecs[0] = '{regs: {8{5'h00}}, mask: 8'hFF, lz: 1'b0, exp: {8{8'hC0}}};
        vecs[1] = '{regs: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h02, 5'h00},
                    mask: 8'hFF, lz: 1'b1,
                    exp: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hC0}};
        vecs[2] = '{regs: {8{5'h00}}, mask: 8'hFF, lz: 1'b1,
                    exp: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{regs: {5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00},
                    mask: 8'hF7, lz: 1'b0,
                    exp: {8'hF8, 8'h82, 8'h92, 8'h99, 8'hFF, 8'hA4, 8'hF9, 8'hC0}};
        vecs[4] = '{regs: {5'h1F, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A, 5'h09, 5'h18},
                    mask: 8'hFF, lz: 1'b1,
                    exp: {8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h00}};
        vecs[5] = '{regs: {5'h00, 5'h00, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},
                    mask: 8'hDF, lz: 1'b1,
                    exp: {8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};

        startSeg = '{8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF};
        startSel = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

        // Reset values, then the first blank/show/blank sequence after release.
        repeat (3) @(negedge clk);
        checkOutput("rst_seg", seg_n, 8'hFF);
        checkOutput("rst_sel", {5'b0, dig_sel}, 8'h00);
        checkOutput("rst_tick", {7'b0, frame_tick}, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("start_seg%0d", i), seg_n, startSeg[i]);
            checkOutput($sformatf("start_sel%0d", i), {5'b0, dig_sel}, {5'b0, startSel[i]});
        end

        // A write during digit 3's lit slot shows up one edge later.
        syncFrame();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h05;
        tick();
        wr_en = 1'b0;
        stepTo(SLOT * 3 + 2);
        checkOutput("wr_first", seg_n, 8'h92);
        stepTo(SLOT * 3 + 3);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h15;
        tick();
        wr_en = 1'b0;
        checkOutput("wr_same_edge", seg_n, 8'h92);
        tick();
        checkOutput("wr_next_edge", seg_n, 8'h12);
        checkOutput("wr_sel", {5'b0, dig_sel}, 8'h03);

        // Free run: tick spacing, tick width and digit stepping.
        lastTick = -1;
        ticks = 0;
        prevTick = frame_tick;
        prevSel = dig_sel;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (frame_tick === 1'b1) begin
                ticks++;
                checkOutput("tick_width", {7'b0, prevTick}, 8'h00);
                checkOutput("tick_sel", {5'b0, dig_sel}, 8'h00);
                if (lastTick >= 0) checkInt("tick_period", i - lastTick, FRAME);
                lastTick = i;
            end
            if (dig_sel !== prevSel) begin
                checkOutput("sel_step", {5'b0, dig_sel}, {5'b0, 3'(prevSel + 3'd1)});
            end
            prevTick = frame_tick;
            prevSel = dig_sel;
        end
        checkInt("tick_count", ticks, 4);

        for (int v = 0; v < 6; v++) applyStimulus(v);

        // A masked digit stays dark through its whole lit slot without disturbing timing.
        writeRegs(vecs[3].regs);
        dig_en_mask = 8'hF7;
        lz_blank = 1'b0;
        syncFrame();
        for (int t = SLOT * 3 + 2; t < SLOT * 4; t++) begin
            stepTo(t);
            checkOutput($sformatf("mask_slot_t%0d", t), seg_n, 8'hFF);
        end
        measurePeriod("mask_period");

        // Asynchronous reset in the middle of digit 5 clears registers and outputs at once.
        writeRegs({5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01});
        dig_en_mask = 8'hFF;
        lz_blank = 1'b0;
        syncFrame();
        stepTo(SLOT * 5 + 3);
        checkOutput("pre_rst_seg", seg_n, 8'h82);
        checkOutput("pre_rst_sel", {5'b0, dig_sel}, 8'h05);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_seg", seg_n, 8'hFF);
        checkOutput("async_rst_sel", {5'b0, dig_sel}, 8'h00);
        checkOutput("async_rst_tick", {7'b0, frame_tick}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        syncFrame();
        for (int k = 0; k < 8; k++) begin
            stepTo(SLOT * k + 3);
            checkOutput($sformatf("post_rst_seg%0d", k), seg_n, 8'hC0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
